// File: rtl/merge_2x8x8b_seq.sv
// merge_2x8x8b_seq
// Merges two ascending lists of eight unsigned bytes into one ascending
// stream of sixteen bytes, emitting one element per accepted output cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   a_in       list A, element i in a_in[8i+7:8i], element 0 smallest
//   b_in       list B, same packing
//   in_valid   an A/B pair is offered
//   in_ready   block is idle and will take the pair
//   out_data   merged element
//   out_valid  out_data holds a valid element
//   out_ready  downstream takes out_data this cycle
//   out_last   out_data is the 16th element of the merge
//   order_err  the most recently loaded A or B was not ascending
//   busy       a merge is in progress
module merge_2x8x8b_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] a_in,
  input  logic [63:0] b_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        order_err,
  output logic        busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] MERGE = 1'b1;

  // Returns 1 when some element is greater than its successor.
  function automatic logic list_unsorted(input logic [63:0] lst);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (lst[8*i +: 8] > lst[8*(i+1) +: 8]) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  logic [0:0]  state_r;
  logic [0:0]  state_next_s;
  logic [63:0] a_r;
  logic [63:0] b_r;
  logic [3:0]  ia_r;
  logic [3:0]  ib_r;
  logic [7:0]  out_data_r;
  logic        out_valid_r;
  logic        out_last_r;
  logic        order_err_r;
  logic        in_ready_r;

  logic        accept_s;
  logic        hs_s;
  logic        done_s;
  logic        load_s;
  logic [63:0] src_a_s;
  logic [63:0] src_b_s;
  logic [3:0]  ia_s;
  logic [3:0]  ib_s;
  logic [7:0]  elem_a_s;
  logic [7:0]  elem_b_s;
  logic        take_a_s;
  logic [7:0]  sel_data_s;
  logic        last_next_s;

  assign in_ready  = in_ready_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign order_err = order_err_r;
  assign busy      = (state_r == MERGE);

  // Handshakes, next state and selection of the next merged element.
  // On the accept edge the first element is chosen straight from the input
  // ports so that out_valid rises the very next cycle; ia/ib then count
  // how many elements of each list have been moved into the output register.
  always_comb begin
    accept_s = in_valid && in_ready_r;
    hs_s     = out_valid_r && out_ready;
    done_s   = hs_s && out_last_r;
    load_s   = accept_s || ((state_r == MERGE) && hs_s && !out_last_r);

    if (accept_s) begin
      src_a_s = a_in;
      src_b_s = b_in;
      ia_s    = 4'd0;
      ib_s    = 4'd0;
    end else begin
      src_a_s = a_r;
      src_b_s = b_r;
      ia_s    = ia_r;
      ib_s    = ib_r;
    end

    // Index 8 means the list is exhausted; the low three bits then wrap,
    // which is harmless because take_a_s ignores that list's element.
    elem_a_s = src_a_s[{ia_s[2:0], 3'b000} +: 8];
    elem_b_s = src_b_s[{ib_s[2:0], 3'b000} +: 8];

    if (ib_s == 4'd8) begin
      take_a_s = 1'b1;
    end else if (ia_s == 4'd8) begin
      take_a_s = 1'b0;
    end else begin
      take_a_s = (elem_a_s <= elem_b_s);
    end

    if (take_a_s) begin
      sel_data_s = elem_a_s;
    end else begin
      sel_data_s = elem_b_s;
    end

    last_next_s = ((ia_s + ib_s) == 4'd15);

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = MERGE;
        end else begin
          state_next_s = IDLE;
        end
      end
      MERGE: begin
        if (done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = MERGE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, ready flag and captured input lists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      a_r         <= 64'h0;
      b_r         <= 64'h0;
      order_err_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s == IDLE);
      if (accept_s) begin
        a_r         <= a_in;
        b_r         <= b_in;
        order_err_r <= list_unsorted(a_in) || list_unsorted(b_in);
      end
    end
  end

  // Output register and read indices; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ia_r        <= 4'd0;
      ib_r        <= 4'd0;
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (load_s) begin
      ia_r        <= ia_s + {3'b000, take_a_s};
      ib_r        <= ib_s + {3'b000, !take_a_s};
      out_data_r  <= sel_data_s;
      out_valid_r <= 1'b1;
      out_last_r  <= last_next_s;
    end else if (done_s) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_merge_2x8x8b_seq.sv
module tb_merge_2x8x8b_seq;

  logic        clk;
  logic        rst_n;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        order_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_data [16];
  int         exp_acnt [16];
  logic       exp_err;

  merge_2x8x8b_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (a_in),
    .b_in      (b_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .order_err (order_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_step(input int base, input int step);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(base + step * i);
    return r;
  endfunction

  function automatic logic [63:0] rand_sorted();
    logic [63:0] r;
    int v;
    v = int'($urandom_range(0, 40));
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = 8'(v);
      v = v + int'($urandom_range(0, 30));
    end
    return r;
  endfunction

  // Reference: two-queue merge, ties to A, plus ascending check.
  task automatic build_model(input logic [63:0] a, input logic [63:0] b);
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int acnt;
    qa = {};
    qb = {};
    exp_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      qa.push_back(a[8*i +: 8]);
      qb.push_back(b[8*i +: 8]);
    end
    for (int i = 0; i < 7; i++) begin
      if (qa[i] > qa[i+1] || qb[i] > qb[i+1]) exp_err = 1'b1;
    end
    acnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (qb.size() == 0 || (qa.size() != 0 && qa[0] <= qb[0])) begin
        exp_data[k] = qa.pop_front();
        acnt++;
      end else begin
        exp_data[k] = qb.pop_front();
      end
      exp_acnt[k] = acnt;
    end
  endtask

  // mode: 0 always ready, 1 ready toggles 1,0,1,0..., 2 random ready.
  task automatic run_merge(input logic [63:0] a, input logic [63:0] b, input int mode,
                           input int abort_after, input bit hold_valid);
    int waitc;
    int n;
    int cyc;
    bit rdy;
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    build_model(a, b);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 16 && cyc < 200) begin
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data", 32'(out_data), 32'(exp_data[n]));
      check("out_last", 32'(out_last), 32'(n == 15));
      check("busy", 32'(busy), 32'd1);
      check("in_ready_busy", 32'(in_ready), 32'd0);
      check("a_count", 32'(dut.ia_r), 32'(exp_acnt[n]));
      check("order_err", 32'(order_err), 32'(exp_err));
      if (hold_valid) begin
        a_in = {$urandom(), $urandom()};
        b_in = {$urandom(), $urandom()};
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) n++;
      if (abort_after != 0 && n == abort_after) begin
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ia", 32'(dut.ia_r), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("merge_count", 32'(n), 32'd16);
    check("after_out_valid", 32'(out_valid), 32'd0);
    check("after_out_last", 32'(out_last), 32'd0);
    check("after_in_ready", 32'(in_ready), 32'd1);
    check("after_busy", 32'(busy), 32'd0);
    check("after_order_err", 32'(order_err), 32'(exp_err));
  endtask

  initial begin
    logic [63:0] ta;
    logic [63:0] tb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = 64'h0;
    b_in = 64'h0;
    @(negedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_last", 32'(out_last), 32'd0);
    check("reset_order_err", 32'(order_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_in_ready", 32'(in_ready), 32'd1);

    // Interleaved evens/odds with continuous ready.
    run_merge(pack_step(0, 2), pack_step(1, 2), 0, 0, 1'b0);

    // All-equal lists.
    run_merge(pack_step(5, 0), pack_step(5, 0), 0, 0, 1'b0);

    // Tie handling: A's fives must all leave before B's.
    tb = pack_step(5, 0);
    tb[63:56] = 8'h06;
    run_merge(pack_step(5, 0), tb, 0, 0, 1'b0);

    // B entirely below A with alternating ready.
    run_merge(pack_step(16, 1), pack_step(0, 1), 1, 0, 1'b0);

    // Unsorted A: error flag, still sixteen outputs.
    ta = pack_step(0, 16);
    ta[31:24] = 8'hFF;
    ta[39:32] = 8'h01;
    run_merge(ta, pack_step(3, 7), 0, 0, 1'b0);

    // Next clean accept clears the flag.
    run_merge(rand_sorted(), rand_sorted(), 2, 0, 1'b0);

    // Reset after the fifth handshake, then a full restart.
    ta = rand_sorted();
    tb = rand_sorted();
    run_merge(ta, tb, 0, 5, 1'b0);
    run_merge(ta, tb, 0, 0, 1'b0);

    // in_valid held with changing inputs during the merge.
    run_merge(rand_sorted(), rand_sorted(), 2, 0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      run_merge(rand_sorted(), rand_sorted(), (r % 2 == 0) ? 2 : 0, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
